// File: rtl/led_code_scheduler.sv
// led_code_scheduler
//   Shares one status LED between NUM_REQ requesters. Each requester
//   reports a small numeric code as a burst of blinks. Requesters are
//   served round-robin; each burst is N blinks (PULSE_CYC on, PULSE_CYC
//   off) followed by a dark gap of GAP_CYC, then a one-cycle done pulse
//   goes back to the served requester.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-low
//   req    in   [NUM_REQ]            per-requester level request, held until grant
//   code   in   [NUM_REQ*CODE_WIDTH] requester i code at [i*CODE_WIDTH +: CODE_WIDTH]
//   abort  in   synchronous abort of the burst in progress
//   grant  out  [NUM_REQ] one-hot pulse: requester accepted, code latched
//   done   out  [NUM_REQ] one-hot pulse: served burst finished or aborted
//   busy   out  high in ON, OFF and GAP
//   led    out  LED drive, 1 = on
module led_code_scheduler #(
  parameter int CLK_FREQ_KHz = 50000,
  parameter int PULSE_MS     = 200,
  parameter int GAP_MS       = 1000,
  parameter int NUM_REQ      = 4,
  parameter int CODE_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CODE_WIDTH-1:0]  code,
  input  logic                           abort,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic                           led
);

  localparam int PULSE_CYC = CLK_FREQ_KHz * PULSE_MS;
  localparam int GAP_CYC   = CLK_FREQ_KHz * GAP_MS;
  localparam int MAX_CYC   = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W     = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CODE_WIDTH-1:0] rem, rem_nxt;
  logic [IDX_W-1:0]      owner, owner_nxt;
  logic [IDX_W-1:0]      last_grant, last_nxt;
  logic                  zero_pend, zero_pend_nxt;
  logic [NUM_REQ-1:0]    grant_nxt, done_nxt;
  logic                  busy_nxt, led_nxt;

  logic [CODE_WIDTH-1:0] code_arr [NUM_REQ];
  logic [IDX_W-1:0]      win, cand;
  logic                  found;
  int                    idx;
  logic [NUM_REQ-1:0]    oh_win, oh_owner;
  logic                  pulse_end, gap_end;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      code_arr[i] = code[i*CODE_WIDTH +: CODE_WIDTH];
    end
  end

  // Round-robin search: first set req bit upward from last_grant+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = last_grant;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign oh_win    = NUM_REQ'(1) << win;
  assign oh_owner  = NUM_REQ'(1) << owner;
  assign pulse_end = (cnt == CNT_W'(PULSE_CYC - 1));
  assign gap_end   = (cnt == CNT_W'(GAP_CYC - 1));

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rem_nxt       = rem;
    owner_nxt     = owner;
    last_nxt      = last_grant;
    zero_pend_nxt = 1'b0;
    grant_nxt     = '0;
    done_nxt      = '0;
    busy_nxt      = 1'b0;
    led_nxt       = 1'b0;

    if (abort && (state != IDLE)) begin
      // Abort wins over any phase end, so a coinciding gap end still yields one done.
      done_nxt  = oh_owner;
      state_nxt = IDLE;
      cnt_nxt   = '0;
      rem_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (zero_pend) begin
            // Code 0: no blinks, just report completion one cycle after grant.
            done_nxt = oh_owner;
          end else if (found) begin
            grant_nxt = oh_win;
            owner_nxt = win;
            last_nxt  = win;
            rem_nxt   = code_arr[win];
            cnt_nxt   = '0;
            if (code_arr[win] != '0) begin
              state_nxt = ON;
              led_nxt   = 1'b1;
              busy_nxt  = 1'b1;
            end else begin
              zero_pend_nxt = 1'b1;
            end
          end
        end
        ON: begin
          busy_nxt = 1'b1;
          if (pulse_end) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
            led_nxt = 1'b1;
          end
        end
        OFF: begin
          busy_nxt = 1'b1;
          if (pulse_end) begin
            cnt_nxt = '0;
            rem_nxt = rem - CODE_WIDTH'(1);
            if (rem != CODE_WIDTH'(1)) begin
              state_nxt = ON;
              led_nxt   = 1'b1;
            end else begin
              state_nxt = GAP;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            done_nxt  = oh_owner;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt  = cnt + CNT_W'(1);
            busy_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      zero_pend  <= 1'b0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      led        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rem        <= rem_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
      zero_pend  <= zero_pend_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      led        <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_code_scheduler.sv
// tb_led_code_scheduler
//   Scoreboard bench for led_code_scheduler with PULSE_CYC=2, GAP_CYC=5.
//   Expected per-cycle {grant, done, busy, led} vectors are queued when a
//   request is driven and popped one per clock as the DUT runs.
module tb_led_code_scheduler;

  localparam int NR  = 4;
  localparam int CW  = 4;
  localparam int P   = 2;
  localparam int GC  = 5;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*CW-1:0]  code;
  logic              abort;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic              led;

  led_code_scheduler #(
    .CLK_FREQ_KHz(1),
    .PULSE_MS    (2),
    .GAP_MS      (5),
    .NUM_REQ     (NR),
    .CODE_WIDTH  (CW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .code (code),
    .abort(abort),
    .grant(grant),
    .done (done),
    .busy (busy),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] exp_q [$];
  int         n_vec;
  int         n_miss;
  string      tag;
  logic       auto_release;

  task automatic check_vec(input string t, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got {grant,done,busy,led}=%b_%b_%b_%b expected %b_%b_%b_%b",
               t, $time, obs[9:6], obs[5:2], obs[1], obs[0],
               exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Expected trace of one burst starting at its grant cycle (t=0).
  task automatic push_burst(input int r, input int n, input int abort_off);
    int total;
    logic [3:0] oh;
    logic [3:0] g, d;
    logic b, l;
    oh = 4'b0001 << r;
    if (abort_off >= 0)  total = abort_off + 1;
    else if (n == 0)     total = 1;
    else                 total = 2 * n * P + GC;
    for (int t = 0; t <= total; t++) begin
      g = (t == 0) ? oh : 4'b0000;
      d = (t == total) ? oh : 4'b0000;
      b = (n != 0) && (t < total);
      l = b && (t < 2 * n * P) && ((t % (2 * P)) < P);
      exp_q.push_back({g, d, b, l});
    end
  endtask

  task automatic set_code(input int r, input int n);
    logic [3:0] v;
    v = n[3:0];
    code[r*CW +: CW] = v;
  endtask

  // One clock: sample just after the edge, compare, then drive next inputs.
  task automatic run(input int ncyc, input int abort_step);
    logic [9:0] exp;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) exp = exp_q.pop_front();
      else                   exp = '0;
      check_vec(tag, {grant, done, busy, led}, exp);
      if (auto_release) req = req & ~grant;
      abort = (i == abort_step);
    end
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    auto_release = 1'b1;
    rst          = 1'b0;
    req          = 4'b1111;
    code         = '0;
    abort        = 1'b0;

    tag = "reset_hold";
    run(3, -1);
    rst = 1'b1;

    // All four requesters with code 0: grants rotate 0,1,2,3, two cycles each.
    tag = "rr_code0";
    for (int r = 0; r < NR; r++) push_burst(r, 0, -1);
    run(9, -1);

    // Simultaneous 0 and 2 with code 1, twice: 0 first both times.
    tag = "rr_pair";
    set_code(0, 1);
    set_code(2, 1);
    req = 4'b0101;
    push_burst(0, 1, -1);
    push_burst(2, 1, -1);
    run(20, -1);
    tag = "rr_pair2";
    req = 4'b0101;
    push_burst(0, 1, -1);
    push_burst(2, 1, -1);
    run(21, -1);

    tag = "code3";
    set_code(0, 3);
    req = 4'b0001;
    push_burst(0, 3, -1);
    run(19, -1);

    tag = "code0_req1";
    set_code(1, 0);
    req = 4'b0010;
    push_burst(1, 0, -1);
    run(3, -1);

    // Abort in OFF phase at G+3; pending requester 3 granted at G+5.
    tag = "abort_off";
    set_code(2, 2);
    set_code(3, 1);
    req = 4'b1100;
    push_burst(2, 2, 3);
    push_burst(3, 1, -1);
    run(16, 3);

    // Abort coinciding with the last gap cycle: exactly one done.
    tag = "abort_gap_end";
    set_code(0, 1);
    req = 4'b0001;
    push_burst(0, 1, 8);
    run(12, 8);

    // Abort while idle is ignored.
    tag = "abort_idle";
    set_code(1, 1);
    req   = 4'b0010;
    abort = 1'b1;
    push_burst(1, 1, -1);
    run(11, -1);

    // Reset mid-burst: outputs drop without a clock edge, no done, re-grant after.
    tag = "rst_mid";
    auto_release = 1'b0;
    set_code(0, 5);
    req = 4'b0001;
    push_burst(0, 5, -1);
    run(7, -1);
    exp_q.delete();
    #2;
    rst = 1'b0;
    #1;
    check_vec("rst_async", {grant, done, busy, led}, 10'b0);
    tag = "rst_mid_hold";
    run(2, -1);
    rst = 1'b1;
    tag = "rst_regrant";
    push_burst(0, 5, -1);
    run(1, -1);
    req          = 4'b0000;
    auto_release = 1'b1;
    run(26, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
